// File: rtl/stack_pkg.sv
// Shared definitions for the stack-pointer bank and the data-memory address mux:
// FSM encoding, default top page, and the context -> page / pointer mapping.
package stack_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_PUSH_ISSUE = 2'd1;
    localparam logic [1:0] ST_POP_WAIT   = 2'd2;

    localparam logic [7:0] TOP_PAGE_DEF  = 8'h2b;

    // Stacks grow downward in page space; callers truncate to PAGE_W (modulo wrap).
    function automatic int unsigned ctx_page(input int unsigned top_page, input int unsigned ctx);
        return top_page - ctx;
    endfunction

    function automatic int unsigned ctx_ptr_idx(input int unsigned ctx, input int unsigned num_ptr);
        return ctx % num_ptr;
    endfunction

endpackage

// File: rtl/stack_ptr_cell.sv
// Single saturating up/down stack pointer with clear; optional high watermark
// enabled by STACK_PTR_BANK_HWM_EN.
module stack_ptr_cell #(
    parameter int PTR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [PTR_W-1:0] ptr_o,
    output logic [PTR_W-1:0] hwm_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Clear wins over a pending decrement so an aborted pop does not move the pointer.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i)
            ptr_d = '0;
        else if (inc_i && (ptr_q != '1))
            ptr_d = ptr_q + PTR_W'(1);
        else if (dec_i && (ptr_q != '0))
            ptr_d = ptr_q - PTR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

`ifdef STACK_PTR_BANK_HWM_EN
    logic [PTR_W-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (clr_i)
            hwm_d = '0;
        else if (ptr_d > hwm_q)
            hwm_d = ptr_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hwm_q <= '0;
        else
            hwm_q <= hwm_d;
    end

    assign hwm_o = hwm_q;
`else
    assign hwm_o = '0;
`endif

endmodule

// File: rtl/stack_ptr_bank.sv
// Stack-pointer bank: NUM_PTR pointers shared by NUM_CTX contexts, push/pop address
// sequencing and overflow/underflow reporting. Watermark via STACK_PTR_BANK_HWM_EN.
module stack_ptr_bank
    import stack_pkg::*;
#(
    parameter int                NUM_CTX  = 16,
    parameter int                NUM_PTR  = 4,
    parameter int                PTR_W    = 8,
    parameter int                PAGE_W   = 8,
    parameter logic [PAGE_W-1:0] TOP_PAGE = PAGE_W'(TOP_PAGE_DEF),
    localparam int               CTX_W    = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
    localparam int               ADDR_W   = PAGE_W + PTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              push_i,
    input  logic [CTX_W-1:0]  ctx_i,
    input  logic              clr_i,
    input  logic              mem_ack_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              addr_valid_o,
    output logic              addr_we_o,
    output logic              ovf_o,
    output logic              unf_o,
    output logic              ovf_sticky_o,
    output logic              unf_sticky_o,
    output logic [PTR_W-1:0]  hwm_o
);

    localparam int IDX_W = (NUM_PTR > 1) ? $clog2(NUM_PTR) : 1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_valid_q, addr_valid_d;
    logic              addr_we_q, addr_we_d;
    logic [IDX_W-1:0]  act_idx_q, act_idx_d;
    logic [IDX_W-1:0]  last_idx_q, last_idx_d;
    logic              ovf_q, unf_q;
    logic              ovf_sticky_q, ovf_sticky_d;
    logic              unf_sticky_q, unf_sticky_d;

    logic [PTR_W-1:0]  ptr_val [NUM_PTR];
    logic [PTR_W-1:0]  hwm_val [NUM_PTR];

    logic              req_acc;
    logic [IDX_W-1:0]  req_idx;
    logic [PAGE_W-1:0] req_page;
    logic [PTR_W-1:0]  req_ptr;
    logic              push_ok, pop_ok, ovf_evt, unf_evt, dec_fire;

    assign req_acc  = req_valid_i && (state_q == ST_IDLE);
    assign req_idx  = IDX_W'(ctx_ptr_idx(32'(ctx_i), int'(NUM_PTR)));
    assign req_page = PAGE_W'(ctx_page(32'(TOP_PAGE), 32'(ctx_i)));
    assign req_ptr  = ptr_val[req_idx];

    assign push_ok  = req_acc &&  push_i && (req_ptr != '1);
    assign ovf_evt  = req_acc &&  push_i && (req_ptr == '1);
    assign pop_ok   = req_acc && !push_i && (req_ptr != '0);
    assign unf_evt  = req_acc && !push_i && (req_ptr == '0);
    assign dec_fire = (state_q == ST_POP_WAIT) && mem_ack_i;

    generate
        for (genvar gi = 0; gi < NUM_PTR; gi++) begin : g_ptr
            logic clr_this;
            // A request accepted in the same cycle owns its pointer; clear is suppressed there.
            assign clr_this = clr_i && (last_idx_q == IDX_W'(gi))
                              && !(req_acc && (req_idx == IDX_W'(gi)));

            stack_ptr_cell #(
                .PTR_W (PTR_W)
            ) u_cell (
                .clk   (clk),
                .rst   (rst),
                .inc_i (push_ok && (req_idx == IDX_W'(gi))),
                .dec_i (dec_fire && (act_idx_q == IDX_W'(gi))),
                .clr_i (clr_this),
                .ptr_o (ptr_val[gi]),
                .hwm_o (hwm_val[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        addr_d       = '0;
        addr_valid_d = 1'b0;
        addr_we_d    = 1'b0;
        act_idx_d    = act_idx_q;
        last_idx_d   = last_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (req_acc)
                    last_idx_d = req_idx;
                if (push_ok) begin
                    state_d      = ST_PUSH_ISSUE;
                    addr_d       = {req_page, req_ptr + PTR_W'(1)};
                    addr_valid_d = 1'b1;
                    addr_we_d    = 1'b1;
                end else if (pop_ok) begin
                    state_d      = ST_POP_WAIT;
                    addr_d       = {req_page, req_ptr};
                    addr_valid_d = 1'b1;
                    act_idx_d    = req_idx;
                end
            end
            ST_PUSH_ISSUE: state_d = ST_IDLE;
            ST_POP_WAIT: begin
                if (mem_ack_i) begin
                    state_d = ST_IDLE;
                end else begin
                    addr_d       = addr_q;
                    addr_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A new overflow/underflow event beats a simultaneous clear.
    assign ovf_sticky_d = ovf_evt || (ovf_sticky_q && !clr_i);
    assign unf_sticky_d = unf_evt || (unf_sticky_q && !clr_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            addr_we_q    <= 1'b0;
            act_idx_q    <= '0;
            last_idx_q   <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            addr_we_q    <= addr_we_d;
            act_idx_q    <= act_idx_d;
            last_idx_q   <= last_idx_d;
            ovf_q        <= ovf_evt;
            unf_q        <= unf_evt;
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign addr_o       = addr_q;
    assign addr_valid_o = addr_valid_q;
    assign addr_we_o    = addr_we_q;
    assign ovf_o        = ovf_q;
    assign unf_o        = unf_q;
    assign ovf_sticky_o = ovf_sticky_q;
    assign unf_sticky_o = unf_sticky_q;
    assign hwm_o        = hwm_val[last_idx_q];

endmodule

// File: tb/tb_stack_ptr_bank.sv
// Directed bench for stack_ptr_bank with hand-computed addresses and flags.
module tb_stack_ptr_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, push_i, clr_i, mem_ack_i;
    logic [3:0]  ctx_i;
    logic        req_ready_o, addr_valid_o, addr_we_o;
    logic [15:0] addr_o;
    logic        ovf_o, unf_o, ovf_sticky_o, unf_sticky_o;
    logic [7:0]  hwm_o;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    stack_ptr_bank dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .push_i       (push_i),
        .ctx_i        (ctx_i),
        .clr_i        (clr_i),
        .mem_ack_i    (mem_ack_i),
        .addr_o       (addr_o),
        .addr_valid_o (addr_valid_o),
        .addr_we_o    (addr_we_o),
        .ovf_o        (ovf_o),
        .unf_o        (unf_o),
        .ovf_sticky_o (ovf_sticky_o),
        .unf_sticky_o (unf_sticky_o),
        .hwm_o        (hwm_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_push(input logic [3:0] ctx, input logic [15:0] exp_addr, input string tag);
        req_valid_i = 1'b1; push_i = 1'b1; ctx_i = ctx;
        tick();
        req_valid_i = 1'b0;
        chk_vec({tag, "_addr"}, 32'(addr_o), 32'(exp_addr));
        chk_vec({tag, "_vld"}, 32'(addr_valid_o), 32'd1);
        chk_vec({tag, "_we"}, 32'(addr_we_o), 32'd1);
        $display("push ctx=%0d addr=%h", ctx, addr_o);
        tick();
    endtask

    task automatic do_pop(input logic [3:0] ctx, input logic [15:0] exp_addr, input int ack_after,
                          input string tag);
        req_valid_i = 1'b1; push_i = 1'b0; ctx_i = ctx;
        tick();
        req_valid_i = 1'b0;
        chk_vec({tag, "_addr"}, 32'(addr_o), 32'(exp_addr));
        chk_vec({tag, "_vld"}, 32'(addr_valid_o), 32'd1);
        chk_vec({tag, "_we"}, 32'(addr_we_o), 32'd0);
        for (int k = 1; k < ack_after; k++) begin
            tick();
            chk_vec({tag, "_hold"}, 32'(addr_o), 32'(exp_addr));
            chk_vec({tag, "_hold_vld"}, 32'(addr_valid_o), 32'd1);
        end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        chk_vec({tag, "_done_vld"}, 32'(addr_valid_o), 32'd0);
        chk_vec({tag, "_done_rdy"}, 32'(req_ready_o), 32'd1);
        $display("pop ctx=%0d addr=%h", ctx, exp_addr);
    endtask

    initial begin
        rst = 1'b1; req_valid_i = 1'b0; push_i = 1'b0; clr_i = 1'b0; mem_ack_i = 1'b0; ctx_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk_vec("rst_rdy", 32'(req_ready_o), 32'd1);
        chk_vec("rst_vld", 32'(addr_valid_o), 32'd0);
        chk_vec("rst_addr", 32'(addr_o), 32'd0);
        chk_vec("rst_flags", {28'd0, ovf_o, unf_o, ovf_sticky_o, unf_sticky_o}, 32'd0);
        chk_vec("rst_hwm", 32'(hwm_o), 32'd0);
        $display("reset released");

        // First push on context 0: address one cycle later, ready back after one busy cycle.
        req_valid_i = 1'b1; push_i = 1'b1; ctx_i = 4'd0;
        tick();
        req_valid_i = 1'b0;
        chk_vec("p0_addr", 32'(addr_o), 32'h2b01);
        chk_vec("p0_we", 32'(addr_we_o), 32'd1);
        chk_vec("p0_vld", 32'(addr_valid_o), 32'd1);
        chk_vec("p0_busy", 32'(req_ready_o), 32'd0);
        tick();
        chk_vec("p0_rdy", 32'(req_ready_o), 32'd1);
        chk_vec("p0_vld_off", 32'(addr_valid_o), 32'd0);
        $display("push ctx=0 addr=2b01");

        // Context 5 -> page 0x26, pointer 1.
        do_push(4'd5, 16'h2601, "c5a");
        do_push(4'd5, 16'h2602, "c5b");
        do_push(4'd5, 16'h2603, "c5c");
        do_pop(4'd5, 16'h2603, 2, "c5pop");
        do_push(4'd5, 16'h2603, "c5re");     // pointer was 2 after the pop

        // Underflow on empty pointer 3.
        req_valid_i = 1'b1; push_i = 1'b0; ctx_i = 4'd3;
        tick();
        req_valid_i = 1'b0;
        chk_vec("unf_pulse", 32'(unf_o), 32'd1);
        chk_vec("unf_sticky", 32'(unf_sticky_o), 32'd1);
        chk_vec("unf_vld", 32'(addr_valid_o), 32'd0);
        chk_vec("unf_rdy", 32'(req_ready_o), 32'd1);
        tick();
        chk_vec("unf_pulse_end", 32'(unf_o), 32'd0);
        chk_vec("unf_sticky_hold", 32'(unf_sticky_o), 32'd1);
        $display("pop ctx=3 underflow");

        // Fill context 2 (page 0x29) to the top, then overflow.
        for (int i = 1; i < 256; i++)
            do_push(4'd2, {8'h29, 8'(i)}, "fill");
        req_valid_i = 1'b1; push_i = 1'b1; ctx_i = 4'd2;
        tick();
        req_valid_i = 1'b0;
        chk_vec("ovf_pulse", 32'(ovf_o), 32'd1);
        chk_vec("ovf_sticky", 32'(ovf_sticky_o), 32'd1);
        chk_vec("ovf_vld", 32'(addr_valid_o), 32'd0);
        chk_vec("ovf_rdy", 32'(req_ready_o), 32'd1);
        tick();
        chk_vec("ovf_pulse_end", 32'(ovf_o), 32'd0);
        $display("push ctx=2 overflow");
        do_pop(4'd2, 16'h29ff, 1, "ovf_pop");  // pointer saturated at 0xff

        // Refill to 0xff, then clear the last-used pointer (2).
        do_push(4'd2, 16'h29ff, "pre_clr");
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk_vec("clr_ovf_sticky", 32'(ovf_sticky_o), 32'd0);
        chk_vec("clr_unf_sticky", 32'(unf_sticky_o), 32'd0);
        chk_vec("clr_hwm", 32'(hwm_o), 32'd0);
        $display("clr ctx=2");
        do_push(4'd2, 16'h2901, "post_clr");   // pointer restarted at 0
        do_push(4'd2, 16'h2902, "hw2");
        do_push(4'd2, 16'h2903, "hw3");
        do_push(4'd2, 16'h2904, "hw4");
        do_pop(4'd2, 16'h2904, 1, "hwpop1");
        do_pop(4'd2, 16'h2903, 3, "hwpop2");
`ifdef STACK_PTR_BANK_HWM_EN
        chk_vec("hwm", 32'(hwm_o), 32'd4);
`else
        chk_vec("hwm_off", 32'(hwm_o), 32'd0);
`endif

        // Asynchronous reset while a pop is outstanding.
        req_valid_i = 1'b1; push_i = 1'b0; ctx_i = 4'd2;
        tick();
        req_valid_i = 1'b0;
        chk_vec("rp_vld", 32'(addr_valid_o), 32'd1);
        chk_vec("rp_addr", 32'(addr_o), 32'h2902);
        #2 rst = 1'b1;
        #1;
        chk_vec("rp_async_vld", 32'(addr_valid_o), 32'd0);
        chk_vec("rp_async_addr", 32'(addr_o), 32'd0);
        chk_vec("rp_async_rdy", 32'(req_ready_o), 32'd1);
        $display("reset during pop");
        tick();
        rst = 1'b0;
        do_push(4'd2, 16'h2901, "after_rst");
        do_push(4'd6, 16'h2502, "shared_ptr");  // ctx 6 shares pointer 2

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
